// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and RS operation encoding for the shift-add multiplier
//
// Purpose : default operand width, derived product/RS widths, and the decoded
//           RS register operation used by the datapath and its bench.
// Ports   : none (package)

package mult_pkg;

  localparam int MULT_WIDTH = 14;
  localparam int PROD_W     = 2 * MULT_WIDTH;
  localparam int RS_W       = 2 * MULT_WIDTH + 1;

  // One decoded operation per edge for the running-sum register.
  typedef enum logic [2:0] {
    RS_HOLD   = 3'd0,
    RS_CLR    = 3'd1,
    RS_ADD    = 3'd2,
    RS_SHR    = 3'd3,
    RS_ADDSHR = 3'd4
  } rs_op_e;

endpackage

// File: rtl/mult_rs_reg.sv
// rtl/mult_rs_reg.sv - running-sum register with upper-half adder and right shifter
//
// Purpose : holds RS (2*WIDTH+1 bits, top bit is the add carry) and applies
//           one decoded operation per clock.
// Ports   :
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-low reset
//   op    in   decoded RS operation (rs_op_e)
//   md    in   multiplicand added into the upper half
//   rs    out  RS[2*WIDTH-1:0]

module mult_rs_reg
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  rs_op_e               op,
  input  logic [WIDTH-1:0]     md,
  output logic [2*WIDTH-1:0]   rs
);

  logic [2*WIDTH:0] rs_q;
  logic [WIDTH:0]   sum;

  // The add deliberately ignores the old carry bit: the upper half plus MD
  // produces a fresh W+1-bit sum that overwrites RS[2W:W].
  assign sum = {1'b0, rs_q[2*WIDTH-1:WIDTH]} + {1'b0, md};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_q <= '0;
    end else begin
      case (op)
        RS_CLR:    rs_q <= '0;
        RS_ADD:    rs_q <= {sum, rs_q[WIDTH-1:0]};
        RS_SHR:    rs_q <= {1'b0, rs_q[2*WIDTH:1]};
        // Add then shift in one edge: the sum's carry lands in bit 2W-1.
        RS_ADDSHR: rs_q <= {1'b0, sum, rs_q[WIDTH-1:1]};
        default:   rs_q <= rs_q;
      endcase
    end
  end

  assign rs = rs_q[2*WIDTH-1:0];

endmodule

// File: rtl/multiplier_datapath.sv
// rtl/multiplier_datapath.sv - shift-add multiplier datapath with product capture and handshake
//
// Purpose : MD/MR operand registers, RS strobe priority decode, and a product
//           output register captured on the rising edge of done.
// Ports   :
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   md_in       in   multiplicand operand
//   mr_in       in   multiplier operand
//   mdld        in   load MD
//   mrld        in   load MR
//   rsload      in   add MD into RS upper half
//   rsclear     in   clear RS (highest priority)
//   rsshr       in   shift RS right by one
//   done        in   controller done flag
//   mr          out  MR register (bit testing by controller)
//   rs          out  live RS[2W-1:0]
//   prod        out  captured product
//   prod_valid  out  prod holds an unconsumed result
//   prod_ready  in   consumer accepts prod
//   overflow    out  sticky: a result was dropped

module multiplier_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     md_in,
  input  logic [WIDTH-1:0]     mr_in,
  input  logic                 mdld,
  input  logic                 mrld,
  input  logic                 rsload,
  input  logic                 rsclear,
  input  logic                 rsshr,
  input  logic                 done,
  output logic [WIDTH-1:0]     mr,
  output logic [2*WIDTH-1:0]   rs,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 prod_valid,
  input  logic                 prod_ready,
  output logic                 overflow
);

  logic [WIDTH-1:0] md_q;
  logic             done_q;
  logic             capture;
  rs_op_e           rs_op;

  // Operand registers. The RS adder sees md_q, so an mdld on the same edge
  // as rsload adds the old MD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_q <= '0;
      mr   <= '0;
    end else begin
      if (mdld) md_q <= md_in;
      if (mrld) mr   <= mr_in;
    end
  end

  always_comb begin
    rs_op = RS_HOLD;
    if (rsclear)              rs_op = RS_CLR;
    else if (rsload && rsshr) rs_op = RS_ADDSHR;
    else if (rsload)          rs_op = RS_ADD;
    else if (rsshr)           rs_op = RS_SHR;
  end

  mult_rs_reg #(.WIDTH(WIDTH)) u_rs (
    .clk (clk),
    .rst (rst),
    .op  (rs_op),
    .md  (md_q),
    .rs  (rs)
  );

  // Only the rising edge of done captures, so a held done yields one result.
  assign capture = done && !done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q     <= 1'b0;
      prod       <= '0;
      prod_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done_q <= done;
      if (capture) begin
        if (!prod_valid || prod_ready) begin
          prod       <= rs;
          prod_valid <= 1'b1;
        end else begin
          // Consumer still owns the previous result: keep it, flag the loss.
          overflow <= 1'b1;
        end
      end else if (prod_valid && prod_ready) begin
        prod_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_datapath.sv
// tb/tb_multiplier_datapath.sv - scoreboard bench for multiplier_datapath (WIDTH=4 and WIDTH=14)

module tb_multiplier_datapath;
  import mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  md_in, mr_in;
  logic        mdld, mrld, rsload, rsclear, rsshr, done, prod_ready;
  logic [3:0]  mr;
  logic [7:0]  rs, prod;
  logic        prod_valid, overflow;

  logic [13:0] md_in14, mr_in14, mr14;
  logic [27:0] rs14, prod14;
  logic        done14, prod_valid14, overflow14;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  multiplier_datapath #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .md_in(md_in), .mr_in(mr_in), .mdld(mdld), .mrld(mrld),
    .rsload(rsload), .rsclear(rsclear), .rsshr(rsshr), .done(done), .mr(mr), .rs(rs),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready), .overflow(overflow)
  );

  multiplier_datapath #(.WIDTH(14)) dut14 (
    .clk(clk), .rst(rst), .md_in(md_in14), .mr_in(mr_in14), .mdld(mdld), .mrld(mrld),
    .rsload(rsload), .rsclear(rsclear), .rsshr(rsshr), .done(done14), .mr(mr14), .rs(rs14),
    .prod(prod14), .prod_valid(prod_valid14), .prod_ready(1'b1), .overflow(overflow14)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a new result is a valid product not already seen (previous
  // sample idle, or previous cycle completed a handshake).
  logic prev_pv = 1'b0;
  logic prev_hs = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      prev_pv = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prod_valid && (!prev_pv || prev_hs)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_prod: got %0h with no result pending", prod);
        end else begin
          check("scoreboard_prod", {24'd0, prod}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_pv = prod_valid;
      prev_hs = prod_valid && prod_ready;
    end
  end

  task automatic drive(input rs_op_e op);
    rsclear = (op == RS_CLR);
    rsload  = (op == RS_ADD) || (op == RS_ADDSHR);
    rsshr   = (op == RS_SHR) || (op == RS_ADDSHR);
    @(negedge clk);
    rsclear = 1'b0;
    rsload  = 1'b0;
    rsshr   = 1'b0;
  endtask

  // Reference: the product is plain md*mr; stimulus follows the controller
  // recipe using the bench's own copy of the multiplier bits.
  task automatic mult(input logic [3:0] a, input logic [3:0] b, input bit fused,
                      input int hold, input bit accepted);
    logic [7:0] p;
    p = a * b;
    md_in = a; mr_in = b; mdld = 1'b1; mrld = 1'b1;
    @(negedge clk);
    mdld = 1'b0; mrld = 1'b0;
    check("mr_port", {28'd0, mr}, {28'd0, b});
    drive(RS_CLR);
    for (int i = 0; i < 4; i++) begin
      if (fused) drive(b[i] ? RS_ADDSHR : RS_SHR);
      else begin
        if (b[i]) drive(RS_ADD);
        drive(RS_SHR);
      end
    end
    check("rs_product", {24'd0, rs}, {24'd0, p});
    if (accepted) exp_q.push_back(p);
    done = 1'b1;
    @(negedge clk);
    if (accepted) begin
      check("valid_after_done", {31'd0, prod_valid}, 32'd1);
      check("prod_after_done", {24'd0, prod}, {24'd0, p});
    end
    repeat (hold - 1) @(negedge clk);
    done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    md_in = '0; mr_in = '0; md_in14 = '0; mr_in14 = '0;
    mdld = 0; mrld = 0; rsload = 0; rsclear = 0; rsshr = 0;
    done = 0; done14 = 0; prod_ready = 1'b1;
    @(negedge clk);
    check("reset_mr", {28'd0, mr}, 32'd0);
    check("reset_rs", {24'd0, rs}, 32'd0);
    check("reset_prod", {24'd0, prod}, 32'd0);
    check("reset_valid", {31'd0, prod_valid}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic and fused multiplies, including zero operands.
    mult(4'd13, 4'd11, 1'b0, 1, 1'b1);
    mult(4'd15, 4'd15, 1'b1, 1, 1'b1);
    mult(4'd0,  4'd9,  1'b1, 1, 1'b1);
    mult(4'd7,  4'd0,  1'b1, 1, 1'b1);

    // Carry retention through two unshifted adds.
    md_in = 4'd15; mdld = 1'b1;
    @(negedge clk);
    mdld = 1'b0;
    drive(RS_CLR);
    drive(RS_ADD);
    drive(RS_ADD);
    check("carry_add_rs", {24'd0, rs}, 32'hE0);
    drive(RS_SHR);
    check("carry_shr_rs", {24'd0, rs}, 32'hF0);

    // Clear wins over load and shift together.
    rsclear = 1'b1; rsload = 1'b1; rsshr = 1'b1;
    @(negedge clk);
    rsclear = 1'b0; rsload = 1'b0; rsshr = 1'b0;
    check("priority_clear", {24'd0, rs}, 32'd0);

    // done held ten cycles: a second capture would reach the monitor with
    // an empty queue.
    mult(4'd5, 4'd6, 1'b0, 10, 1'b1);

    for (int n = 0; n < 20; n++) begin
      mult(4'($urandom), 4'($urandom), 1'($urandom), 1 + int'($urandom_range(2, 0)), 1'b1);
    end

    // Stalled consumer: second result is dropped and flagged.
    prod_ready = 1'b0;
    mult(4'd13, 4'd11, 1'b0, 1, 1'b1);
    mult(4'd3,  4'd5,  1'b0, 1, 1'b0);
    check("stall_prod_held", {24'd0, prod}, 32'd143);
    check("stall_valid", {31'd0, prod_valid}, 32'd1);
    check("stall_overflow", {31'd0, overflow}, 32'd1);
    prod_ready = 1'b1;
    @(negedge clk);
    check("handshake_clears_valid", {31'd0, prod_valid}, 32'd0);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);

    // Asynchronous reset mid-operation with a pending product.
    prod_ready = 1'b0;
    mult(4'd9, 4'd9, 1'b0, 1, 1'b1);
    md_in = 4'd4; mr_in = 4'd5; mdld = 1'b1; mrld = 1'b1;
    @(negedge clk);
    mdld = 1'b0; mrld = 1'b0;
    drive(RS_CLR);
    drive(RS_ADD);
    #2 rst = 1'b0;
    #1;
    check("async_mr", {28'd0, mr}, 32'd0);
    check("async_rs", {24'd0, rs}, 32'd0);
    check("async_prod", {24'd0, prod}, 32'd0);
    check("async_valid", {31'd0, prod_valid}, 32'd0);
    check("async_overflow", {31'd0, overflow}, 32'd0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    prod_ready = 1'b1;
    @(negedge clk);
    check("no_capture_in_reset", {31'd0, prod_valid}, 32'd0);

    // Full-width operands on the 14-bit instance.
    md_in14 = 14'h3FFF; mr_in14 = 14'h3FFF; mdld = 1'b1; mrld = 1'b1;
    @(negedge clk);
    mdld = 1'b0; mrld = 1'b0;
    drive(RS_CLR);
    for (int i = 0; i < 14; i++) begin
      drive(RS_ADD);
      drive(RS_SHR);
    end
    done14 = 1'b1;
    @(negedge clk);
    done14 = 1'b0;
    check("w14_valid", {31'd0, prod_valid14}, 32'd1);
    check("w14_prod", {4'd0, prod14}, 32'h0FFF8001);
    @(negedge clk);
    @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
